// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multicycle MULTU/DIVU unit.
// The pipeline side (master) issues requests and reads HI/LO; the unit (slave) answers.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       alu_ctrl;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output alu_ctrl, start, a, b,
    input  busy, done, stall, hi, lo, result
  );

  modport slave (
    input  alu_ctrl, start, a, b,
    output busy, done, stall, hi, lo, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multicycle unsigned multiply (radix-2 shift-add) and restoring divide with HI/LO registers.
// One bit per cycle, WIDTH cycles per operation; HI/LO are only written on completion.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [3:0] OP_MULTU = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MFHI  = 4'd9;
  localparam logic [3:0] OP_MFLO  = 4'd10;
  localparam int         CNT_W    = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_opd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_ready;
  logic                 w_start_mul;
  logic                 w_start_div;
  logic                 w_busy;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_div_part;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_diff;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_mul = w_ready && bus.start && (bus.alu_ctrl == OP_MULTU);
  assign w_start_div = w_ready && bus.start && (bus.alu_ctrl == OP_DIVU);
  assign w_busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply: acc = {partial product, remaining multiplier bits}; the multiplier LSB
  // gates the add into the upper half, then the whole thing shifts right one place.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; a zero divisor always "fits", which
  // naturally yields an all-ones quotient and the dividend as remainder.
  assign w_div_part = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_part >= {1'b0, r_opd});
  assign w_div_diff = WIDTH'(w_div_part - {1'b0, r_opd});
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_part[WIDTH-1:0];
  assign w_div_acc  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  assign w_acc_next = (r_state == S_MUL) ? w_mul_acc : w_div_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_mul)      w_next = S_MUL;
        else if (w_start_div) w_next = S_DIV;
        else                  w_next = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_opd <= '0;
      r_acc <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_start_mul || w_start_div) begin
      r_cnt <= '0;
      r_opd <= w_start_mul ? bus.a : bus.b;
      r_acc <= {{WIDTH{1'b0}}, (w_start_mul ? bus.b : bus.a)};
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      if (w_last) begin
        r_hi <= w_acc_next[2*WIDTH-1:WIDTH];
        r_lo <= w_acc_next[WIDTH-1:0];
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = (r_state == S_DONE);
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.stall  = w_busy && ((bus.alu_ctrl == OP_MULTU) || (bus.alu_ctrl == OP_DIVU) ||
                                 (bus.alu_ctrl == OP_MFHI)  || (bus.alu_ctrl == OP_MFLO));
  assign bus.result = (bus.alu_ctrl == OP_MFHI) ? r_hi :
                      (bus.alu_ctrl == OP_MFLO) ? r_lo : '0;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; iteration count per operation = WIDTH.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: alu_ctrl  in  4  ALU control code; MULTU=7, DIVU=8, MFHI=9, MFLO=10, all other codes are non-muldiv.
REQ-005 SHALL have port: start  in  1  request qualifier; sampled with alu_ctrl, a, b.
REQ-006 SHALL have port: a  in  WIDTH  rs operand (multiplicand / dividend).
REQ-007 SHALL have port: b  in  WIDTH  rt operand (multiplier / divisor).
REQ-008 SHALL have port: busy  out  1  operation in progress.
REQ-009 SHALL have port: done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-010 SHALL have port: stall  out  1  pipeline hold request.
REQ-011 SHALL have ports: hi, lo  out  WIDTH  architectural HI/LO registers.
REQ-012 SHALL have port: result  out  WIDTH  MFHI/MFLO read data.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 IDLE or DONE: start=1 and alu_ctrl=MULTU SHALL latch a, b, clear iteration counter, enter MUL; alu_ctrl=DIVU likewise enters DIV; any other case SHALL go to or stay in IDLE.
REQ-015 MUL SHALL perform unsigned radix-2 shift-add: one multiplier bit per cycle, 2*WIDTH-bit accumulator, no overflow loss.
REQ-016 DIV SHALL perform unsigned restoring division: one quotient bit per cycle, WIDTH+1-bit partial remainder compare/subtract.
REQ-017 MUL/DIV SHALL each last exactly WIDTH cycles; on the edge ending the last iteration, hi/lo SHALL be written and the FSM SHALL enter DONE.
REQ-018 MULTU SHALL write hi = product[2*WIDTH-1:WIDTH] and lo = product[WIDTH-1:0].
REQ-019 DIVU SHALL write lo = quotient and hi = remainder.
REQ-020 Divide by zero SHALL write lo = all ones and hi = dividend, with no exception or flag.
REQ-021 Latency: start sampled on edge 0 -> busy=1 in cycles 1..WIDTH -> done=1 and new hi/lo visible in cycle WIDTH+1.
REQ-022 busy SHALL be 1 only in MUL/DIV; done SHALL be 1 only in DONE.
REQ-023 start while busy=1 SHALL be ignored: no restart and no operand relatch.
REQ-024 hi/lo SHALL change only at operation completion or reset; intermediate values SHALL never appear on hi/lo.
REQ-025 stall SHALL be combinational: busy=1 and alu_ctrl in {MULTU, DIVU, MFHI, MFLO}.
REQ-026 result SHALL be combinational: hi when alu_ctrl=MFHI, lo when MFLO, else 0.
REQ-027 MFHI/MFLO in the DONE cycle SHALL return the new values, with stall=0.
REQ-028 Back-to-back: start accepted in DONE SHALL begin the next operation with no idle cycle.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force state=IDLE, counter=0, operand/accumulator registers=0, hi=0, lo=0, busy=0, done=0.
REQ-030 rst asserted mid-operation SHALL discard the operation; hi/lo SHALL NOT receive partial results.
REQ-031 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-032 MULTU a=7, b=6 -> cycle 33: done=1, hi=0x00000000, lo=0x0000002A; busy=1 in cycles 1..32.
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 MFHI during an operation -> stall=1 until done; in the done cycle stall=0 and result=new hi; second start mid-operation has no effect.
REQ-036 rst at cycle 10 of a DIVU with prior hi=3 -> hi=0, lo=0, busy=0 immediately; a following MULTU 2*3 gives lo=6 at start+33.
REQ-037 MULTU issued in the DONE cycle of a DIVU -> second done exactly 33 cycles later; hi/lo correct for both operations.
